// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg
//   Shared definitions for the PLL lock supervisor: the FSM state encoding,
//   default timing constants for a 12 MHz reference clock, and a helper that
//   sizes the shared state timer.
//   No ports (package).
package pll_sup_pkg;

  // Supervisor FSM states; the encoding is visible on the debug state port.
  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_t;

  // Defaults for a 12 MHz reference: 16-cycle PLL reset pulse, 10 ms lock
  // timeout, 100 us of continuous lock before the system is released.
  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 120000;
  localparam int unsigned DEF_STABLE_CYCLES       = 1200;
  localparam int unsigned DEF_MAX_RETRIES         = 4;
  localparam int unsigned DEF_SYNC_STAGES         = 2;

  // Width of a timer that must count up to (largest interval - 1). Kept at
  // least one bit wide so degenerate single-cycle settings still elaborate.
  function automatic int unsigned timerWidth(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/bit_sync.sv
// bit_sync
//   Multi-flop synchronizer that brings a single asynchronous bit into the
//   i_clk domain. The output is the input delayed by SYNC_STAGES flops.
//   Ports:
//     i_clk  - destination clock
//     i_rst  - asynchronous active-high reset, clears every stage
//     i_d    - asynchronous input bit
//     o_q    - synchronized bit
module bit_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Shift chain: new sample enters at bit 0, the oldest stage drives o_q.
  // Only the first stage may go metastable; the rest give it time to settle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Drives the PLL reset and qualifies PLL lock before releasing the system
//   reset. Runs on the free-running reference clock. Issues timed PLL reset
//   pulses, retries on lock timeout, gives up into FAULT after MAX_RETRIES
//   timeouts, and records lock losses seen while running.
//   Ports:
//     i_clk_in          - free-running reference clock (12 MHz nominal)
//     i_rst             - asynchronous active-high reset
//     i_pll_locked      - PLL lock, asynchronous to i_clk_in
//     i_restart_req     - single-cycle request to restart the whole sequence
//     i_clear_lost      - clears the sticky lock-lost flag
//     o_pll_rst         - active-high reset to the PLL
//     o_sys_rst         - active-high system reset, low only in RUN
//     o_lock_lost       - sticky: lock dropped while in RUN
//     o_fault           - high in FAULT
//     o_retry_cnt       - lock timeouts in the current sequence
//     o_relock_events   - saturating count of RUN lock losses
//     o_state           - encoded FSM state for debug
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned STABLE_CYCLES       = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int unsigned SYNC_STAGES         = DEF_SYNC_STAGES
) (
  input  logic                               i_clk_in,
  input  logic                               i_rst,
  input  logic                               i_pll_locked,
  input  logic                               i_restart_req,
  input  logic                               i_clear_lost,
  output logic                               o_pll_rst,
  output logic                               o_sys_rst,
  output logic                               o_lock_lost,
  output logic                               o_fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   o_retry_cnt,
  output logic [7:0]                         o_relock_events,
  output logic [2:0]                         o_state
);

  localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);
  localparam int unsigned TIMER_W = timerWidth(LOCK_TIMEOUT_CYCLES, STABLE_CYCLES, PLL_RST_CYCLES);

  localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

  sup_state_t         r_state;
  sup_state_t         w_nextState;
  logic [TIMER_W-1:0] r_timer;
  logic [RETRY_W-1:0] r_retryCnt;
  logic [RETRY_W-1:0] w_nextRetry;
  logic [RETRY_W-1:0] w_retryInc;
  logic [7:0]         r_relockEvents;
  logic               r_lockLost;
  logic               r_pllRst;
  logic               r_sysRst;
  logic               r_fault;
  logic               w_lockS;
  logic               w_lossEvent;
  logic               w_restartTimer;

  // Only the synchronized lock is ever looked at by the FSM.
  bit_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lockSync (
    .i_clk (i_clk_in),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lockS)
  );

  assign w_retryInc = r_retryCnt + RETRY_W'(1);

  // Next-state logic. A restart request overrides everything, including a
  // lock loss in RUN, so it is handled before the per-state decisions. The
  // shared timer restarts whenever the state changes or a restart arrives,
  // which also stretches the PLL reset pulse when restarting from PLL_RST.
  always_comb begin
    w_nextState    = r_state;
    w_nextRetry    = r_retryCnt;
    w_lossEvent    = 1'b0;
    w_restartTimer = 1'b0;
    if (i_restart_req) begin
      w_nextState    = ST_PLL_RST;
      w_nextRetry    = '0;
      w_restartTimer = 1'b1;
    end else begin
      case (r_state)
        ST_PLL_RST: begin
          if (r_timer == PLL_RST_LAST) w_nextState = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lockS) begin
            w_nextState = ST_STABLE;
          end else if (r_timer == TIMEOUT_LAST) begin
            w_nextRetry = w_retryInc;
            w_nextState = (w_retryInc == RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
          end
        end
        ST_STABLE: begin
          if (!w_lockS) begin
            w_nextState = ST_WAIT_LOCK;
          end else if (r_timer == STABLE_LAST) begin
            w_nextState = ST_RUN;
            w_nextRetry = '0;
          end
        end
        ST_RUN: begin
          if (!w_lockS) begin
            w_nextState = ST_PLL_RST;
            w_lossEvent = 1'b1;
          end
        end
        ST_FAULT: begin
          w_nextState = ST_FAULT;
        end
        default: begin
          w_nextState = ST_PLL_RST;
        end
      endcase
    end
    if (w_nextState != r_state) w_restartTimer = 1'b1;
  end

  // State, retry count and the shared timer. The timer only advances in the
  // timed states so it can never wrap while sitting in RUN or FAULT.
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_PLL_RST;
      r_retryCnt <= '0;
      r_timer    <= '0;
    end else begin
      r_state    <= w_nextState;
      r_retryCnt <= w_nextRetry;
      if (w_restartTimer) begin
        r_timer <= '0;
      end else if (r_state == ST_PLL_RST || r_state == ST_WAIT_LOCK || r_state == ST_STABLE) begin
        r_timer <= r_timer + TIMER_W'(1);
      end
    end
  end

  // Outputs are decoded from the next state so the registered values line up
  // exactly with the cycle in which the state register takes that state.
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_pllRst <= 1'b1;
      r_sysRst <= 1'b1;
      r_fault  <= 1'b0;
    end else begin
      r_pllRst <= (w_nextState == ST_PLL_RST);
      r_sysRst <= (w_nextState != ST_RUN);
      r_fault  <= (w_nextState == ST_FAULT);
    end
  end

  // Lock-loss bookkeeping. A loss and a clear in the same cycle leave the
  // flag set so the event is never silently discarded.
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      r_lockLost     <= 1'b0;
      r_relockEvents <= '0;
    end else begin
      if (w_lossEvent) begin
        r_lockLost <= 1'b1;
      end else if (i_clear_lost) begin
        r_lockLost <= 1'b0;
      end
      if (w_lossEvent && r_relockEvents != 8'hFF) begin
        r_relockEvents <= r_relockEvents + 8'd1;
      end
    end
  end

  assign o_pll_rst       = r_pllRst;
  assign o_sys_rst       = r_sysRst;
  assign o_fault         = r_fault;
  assign o_lock_lost     = r_lockLost;
  assign o_retry_cnt     = r_retryCnt;
  assign o_relock_events = r_relockEvents;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Bench for pll_lock_supervisor with short timing parameters. Hand-written
//   sequences cover pulse widths and lock qualification latencies; a vector
//   table (expected values queued as stimulus is applied) covers the
//   timeout/retry/fault path.
module tb_pll_lock_supervisor;

  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_TIMEOUT_CYCLES = 20;
  localparam int STABLE_CYCLES       = 8;
  localparam int MAX_RETRIES         = 2;
  localparam int SYNC_STAGES         = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       pllLocked;
  logic       restartReq;
  logic       clearLost;
  logic       pllRst;
  logic       sysRst;
  logic       lockLost;
  logic       fault;
  logic [1:0] retryCnt;
  logic [7:0] relockEvents;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       locked;
    logic       restart;
    logic       clear;
    int         cycles;
    logic [2:0] state;
    logic       pllRst;
    logic       sysRst;
    logic       lockLost;
    logic       fault;
    logic [1:0] retry;
    logic [7:0] relock;
  } vec_t;

  vec_t vecs[12];
  vec_t expQ[$];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (PLL_RST_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .STABLE_CYCLES       (STABLE_CYCLES),
    .MAX_RETRIES         (MAX_RETRIES),
    .SYNC_STAGES         (SYNC_STAGES)
  ) dut (
    .i_clk_in        (clk),
    .i_rst           (rst),
    .i_pll_locked    (pllLocked),
    .i_restart_req   (restartReq),
    .i_clear_lost    (clearLost),
    .o_pll_rst       (pllRst),
    .o_sys_rst       (sysRst),
    .o_lock_lost     (lockLost),
    .o_fault         (fault),
    .o_retry_cnt     (retryCnt),
    .o_relock_events (relockEvents),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  // Advance n clock edges and settle 1 time unit past the last one; inputs
  // are driven and outputs sampled at that point.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one table row (restart/clear are single-cycle pulses), queue its
  // expected outputs, then let the requested number of cycles elapse.
  task automatic applyStimulus(input vec_t v);
    pllLocked  = v.locked;
    restartReq = v.restart;
    clearLost  = v.clear;
    expQ.push_back(v);
    step(1);
    restartReq = 1'b0;
    clearLost  = 1'b0;
    if (v.cycles > 1) step(v.cycles - 1);
  endtask

  task automatic checkOutput();
    vec_t e;
    if (expQ.size() == 0) begin
      checkVal("queueEmpty", 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkVal("vecState",    32'(state),        32'(e.state));
      checkVal("vecPllRst",   32'(pllRst),       32'(e.pllRst));
      checkVal("vecSysRst",   32'(sysRst),       32'(e.sysRst));
      checkVal("vecLockLost", 32'(lockLost),     32'(e.lockLost));
      checkVal("vecFault",    32'(fault),        32'(e.fault));
      checkVal("vecRetry",    32'(retryCnt),     32'(e.retry));
      checkVal("vecRelock",   32'(relockEvents), 32'(e.relock));
    end
  endtask

  // Count cycles while pll_rst stays high (bounded).
  task automatic measurePllRst(output int cnt);
    cnt = 0;
    while (pllRst && cnt < 50) begin
      cnt++;
      step(1);
    end
  endtask

  // Count cycles until sys_rst reaches the given level (bounded).
  task automatic waitSysRst(input logic level, input int limit, output int n);
    n = 0;
    while (sysRst !== level && n < limit) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   n;
    int   cnt;
    logic [7:0] expRelock;

    //           locked rst clr cyc st   pll sys lost flt rty relock
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 3,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 19, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 19, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1,  3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 10, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 8'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 3,  3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1,  3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd1};

    rst        = 1'b1;
    pllLocked  = 1'b0;
    restartReq = 1'b0;
    clearLost  = 1'b0;
    step(3);

    $display("[TB] reset values");
    checkVal("rstState",    32'(state),        32'd0);
    checkVal("rstPllRst",   32'(pllRst),       32'd1);
    checkVal("rstSysRst",   32'(sysRst),       32'd1);
    checkVal("rstLockLost", 32'(lockLost),     32'd0);
    checkVal("rstFault",    32'(fault),        32'd0);
    checkVal("rstRetry",    32'(retryCnt),     32'd0);
    checkVal("rstRelock",   32'(relockEvents), 32'd0);

    $display("[TB] first lock after reset");
    rst = 1'b0;
    measurePllRst(cnt);
    checkVal("firstPulseWidth", cnt, 32'd4);
    step(3);
    pllLocked = 1'b1;
    waitSysRst(1'b0, 100, n);
    checkVal("firstReleaseLatency", n, 32'd11);
    checkVal("firstRunState", 32'(state),    32'd3);
    checkVal("firstRunRetry", 32'(retryCnt), 32'd0);
    checkVal("firstRunPll",   32'(pllRst),   32'd0);

    $display("[TB] lock loss in RUN");
    pllLocked = 1'b0;
    waitSysRst(1'b1, 20, n);
    checkVal("lossSysRstLatency", n, 32'd3);
    checkVal("lossLockLost", 32'(lockLost),     32'd1);
    checkVal("lossRelock",   32'(relockEvents), 32'd1);
    checkVal("lossState",    32'(state),        32'd0);
    pllLocked = 1'b1;
    measurePllRst(cnt);
    checkVal("lossPulseWidth", cnt, 32'd4);
    waitSysRst(1'b0, 100, n);
    checkVal("relockLatency", n, 32'd9);
    checkVal("relockState", 32'(state), 32'd3);
    clearLost = 1'b1;
    step(1);
    clearLost = 1'b0;
    checkVal("clearLost", 32'(lockLost), 32'd0);

    $display("[TB] lock drop during STABLE");
    restartReq = 1'b1;
    step(1);
    restartReq = 1'b0;
    checkVal("restartRunState",  32'(state),  32'd0);
    checkVal("restartRunSysRst", 32'(sysRst), 32'd1);
    measurePllRst(cnt);
    checkVal("restartPulseWidth", cnt, 32'd4);
    step(6);
    checkVal("stableEntered", 32'(state), 32'd2);
    pllLocked = 1'b0;
    step(2);
    checkVal("stableHolding", 32'(state), 32'd2);
    step(1);
    checkVal("stableDropState", 32'(state),    32'd1);
    checkVal("stableDropRetry", 32'(retryCnt), 32'd0);
    pllLocked = 1'b1;
    waitSysRst(1'b0, 100, n);
    checkVal("stableFullRequal", n, 32'd11);

    $display("[TB] timeout, retry and fault table");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    $display("[TB] relock event saturation");
    pllLocked = 1'b1;
    waitSysRst(1'b0, 100, n);
    checkVal("satStartRun", 32'(state), 32'd3);
    expRelock = 8'd1;
    for (int i = 0; i < 256; i++) begin
      pllLocked = 1'b0;
      waitSysRst(1'b1, 20, n);
      if (expRelock != 8'd255) expRelock = expRelock + 8'd1;
      checkVal("satRelock", 32'(relockEvents), 32'(expRelock));
      pllLocked = 1'b1;
      waitSysRst(1'b0, 100, n);
      checkVal("satRelockTimeout", (n >= 100) ? 32'd1 : 32'd0, 32'd0);
    end
    checkVal("satFinal", 32'(relockEvents), 32'd255);

    $display("[TB] clear coinciding with lock loss");
    clearLost = 1'b1;
    step(1);
    clearLost = 1'b0;
    checkVal("preClear", 32'(lockLost), 32'd0);
    pllLocked = 1'b0;
    step(2);
    clearLost = 1'b1;
    step(1);
    clearLost = 1'b0;
    checkVal("coincideState",    32'(state),        32'd0);
    checkVal("coincideLockLost", 32'(lockLost),     32'd1);
    checkVal("coincideRelock",   32'(relockEvents), 32'd255);
    pllLocked = 1'b1;
    waitSysRst(1'b0, 100, n);
    checkVal("preResetRun", 32'(state), 32'd3);

    $display("[TB] asynchronous reset in RUN");
    step(2);
    rst = 1'b1;
    #1;
    checkVal("asyncState",    32'(state),        32'd0);
    checkVal("asyncPllRst",   32'(pllRst),       32'd1);
    checkVal("asyncSysRst",   32'(sysRst),       32'd1);
    checkVal("asyncLockLost", 32'(lockLost),     32'd0);
    checkVal("asyncFault",    32'(fault),        32'd0);
    checkVal("asyncRetry",    32'(retryCnt),     32'd0);
    checkVal("asyncRelock",   32'(relockEvents), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
